// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter: FSM state encoding and port identifiers.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_START = 3'd1,
    RD_DATA  = 3'd2,
    WR_DATA  = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker. The pointer names the port preferred on contention and
// moves to the port that did not own the burst just completed.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  logic ptr_q;
  logic ptr_d;

  // preferred-port pointer register
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= PORT_I;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // pointer update and one-hot pick
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) begin
      ptr_d = ~last_i;
    end else begin
      ptr_d = ptr_q;
    end
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = (ptr_q == PORT_D) ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between icache (port 0) and dcache (port 1), granting whole
// bursts and steering strobes, address, write data and read beats to the owner.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDRBITS  = 32,
  parameter int DATABITS  = 32,
  parameter int BURSTBITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRBITS-1:0]  p0_addr,
  input  logic [DATABITS-1:0]  p0_in,
  input  logic                 p0_rdreq,
  input  logic                 p0_wrreq,
  input  logic [BURSTBITS-1:0] p0_burstlen,
  output logic [DATABITS-1:0]  p0_out,
  output logic                 p0_out_valid,
  output logic                 p0_grant,
  output logic                 p0_wr_next,
  output logic                 p0_done,
  input  logic [ADDRBITS-1:0]  p1_addr,
  input  logic [DATABITS-1:0]  p1_in,
  input  logic                 p1_rdreq,
  input  logic                 p1_wrreq,
  input  logic [BURSTBITS-1:0] p1_burstlen,
  output logic [DATABITS-1:0]  p1_out,
  output logic                 p1_out_valid,
  output logic                 p1_grant,
  output logic                 p1_wr_next,
  output logic                 p1_done,
  output logic [ADDRBITS-1:0]  mem_addr,
  output logic [DATABITS-1:0]  mem_in,
  input  logic [DATABITS-1:0]  mem_out,
  input  logic                 mem_out_valid,
  output logic                 mem_rdreq,
  output logic                 mem_wrreq,
  output logic [BURSTBITS-1:0] mem_burstlen
);

  localparam logic [BURSTBITS-1:0] LEN_ZERO = {BURSTBITS{1'b0}};
  localparam logic [BURSTBITS-1:0] LEN_ONE  = {{(BURSTBITS-1){1'b0}}, 1'b1};

  function automatic logic [BURSTBITS-1:0] eff_len(input logic [BURSTBITS-1:0] bl);
    if (bl == LEN_ZERO) begin
      eff_len = LEN_ONE;
    end else begin
      eff_len = bl;
    end
  endfunction

  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 wr_q, wr_d;
  logic [BURSTBITS-1:0] len_q, len_d;
  logic [BURSTBITS-1:0] cnt_q, cnt_d;
  logic [1:0]           req_s;
  logic [1:0]           gnt_s;
  logic                 advance_s;
  logic                 last_s;
  logic                 granted_s;
  logic                 rd_phase_s;

  assign req_s  = {p1_rdreq | p1_wrreq, p0_rdreq | p0_wrreq};
  assign last_s = (cnt_q == (len_q - LEN_ONE));

  rr_arbiter2 u_rr (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_s),
    .advance_i (advance_s),
    .last_i    (owner_q),
    .gnt_o     (gnt_s)
  );

  // burst state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= PORT_I;
      wr_q    <= 1'b0;
      len_q   <= LEN_ZERO;
      cnt_q   <= LEN_ZERO;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // next-state: arbitration, beat counting, completion
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    advance_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_s != 2'b00) begin
          owner_d = gnt_s[1] ? PORT_D : PORT_I;
          wr_d    = gnt_s[1] ? p1_wrreq : p0_wrreq;
          len_d   = eff_len(gnt_s[1] ? p1_burstlen : p0_burstlen);
          cnt_d   = LEN_ZERO;
          state_d = (gnt_s[1] ? p1_wrreq : p0_wrreq) ? WR_DATA : RD_START;
        end else begin
          state_d = IDLE;
        end
      end
      // a beat in RD_START comes from zero-wait memory and counts like any other
      RD_START, RD_DATA: begin
        if (mem_out_valid) begin
          if (last_s) begin
            state_d = DONE;
          end else begin
            cnt_d   = cnt_q + LEN_ONE;
            state_d = RD_DATA;
          end
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_DATA: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + LEN_ONE;
          state_d = WR_DATA;
        end
      end
      DONE: begin
        advance_s = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // output decode from the burst registers; read data passes through to the owner only
  always_comb begin
    granted_s    = (state_q == RD_START) || (state_q == RD_DATA) || (state_q == WR_DATA);
    rd_phase_s   = (state_q == RD_START) || (state_q == RD_DATA);
    p0_grant     = granted_s && (owner_q == PORT_I);
    p1_grant     = granted_s && (owner_q == PORT_D);
    mem_rdreq    = (state_q == RD_START);
    mem_wrreq    = (state_q == WR_DATA);
    p0_wr_next   = mem_wrreq && (owner_q == PORT_I);
    p1_wr_next   = mem_wrreq && (owner_q == PORT_D);
    p0_done      = (state_q == DONE) && (owner_q == PORT_I);
    p1_done      = (state_q == DONE) && (owner_q == PORT_D);
    p0_out_valid = p0_grant && rd_phase_s && mem_out_valid;
    p1_out_valid = p1_grant && rd_phase_s && mem_out_valid;
    p0_out       = p0_grant ? mem_out : {DATABITS{1'b0}};
    p1_out       = p1_grant ? mem_out : {DATABITS{1'b0}};
    mem_burstlen = granted_s ? len_q : LEN_ZERO;
    if (p1_grant) begin
      mem_addr = p1_addr;
      mem_in   = p1_in;
    end else if (p0_grant) begin
      mem_addr = p0_addr;
      mem_in   = p0_in;
    end else begin
      mem_addr = {ADDRBITS{1'b0}};
      mem_in   = {DATABITS{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized two-master traffic against a
// transaction-level model and a burst-replaying SPRAM memory.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] mem_out = '0;
  logic          mem_out_valid = 1'b0;
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_in [2];
  logic          m_rd [2];
  logic          m_wr [2];
  logic [BW-1:0] m_bl [2];
  bit            m_act [2];
  bit            m_ab [2];

  logic [DW-1:0] p0_out, p1_out, mem_in;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_burstlen;
  logic p0_out_valid, p0_grant, p0_wr_next, p0_done;
  logic p1_out_valid, p1_grant, p1_wr_next, p1_done;
  logic mem_rdreq, mem_wrreq;

  mem_arbiter #(.ADDRBITS(AW), .DATABITS(DW), .BURSTBITS(BW)) dut (
    .clk(clk), .reset(reset),
    .p0_addr(m_addr[0]), .p0_in(m_in[0]), .p0_rdreq(m_rd[0]), .p0_wrreq(m_wr[0]),
    .p0_burstlen(m_bl[0]), .p0_out(p0_out), .p0_out_valid(p0_out_valid),
    .p0_grant(p0_grant), .p0_wr_next(p0_wr_next), .p0_done(p0_done),
    .p1_addr(m_addr[1]), .p1_in(m_in[1]), .p1_rdreq(m_rd[1]), .p1_wrreq(m_wr[1]),
    .p1_burstlen(m_bl[1]), .p1_out(p1_out), .p1_out_valid(p1_out_valid),
    .p1_grant(p1_grant), .p1_wr_next(p1_wr_next), .p1_done(p1_done),
    .mem_addr(mem_addr), .mem_in(mem_in), .mem_out(mem_out), .mem_out_valid(mem_out_valid),
    .mem_rdreq(mem_rdreq), .mem_wrreq(mem_wrreq), .mem_burstlen(mem_burstlen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // transaction-level model of the arbiter
  bit md_busy = 0, md_fin = 0, md_wr = 0, just_acc = 0;
  int md_owner = 0, md_len = 0, md_beats = 0, md_age = 0, md_ptr = 0;

  // SPRAM model with burst replay
  logic [DW-1:0] mem [0:1023];
  int  rd_left = 0, rd_ptr = 0, stall_pct = 0;
  bit  zw_mode = 0, zw_started = 0, stray_en = 0, force_stray = 0, rnd_mode = 0;
  bit  ob_next [2], ob_done [2];

  // per-scenario statistics
  int st_wr, st_rdreq, st_done [2], st_valid [2], st_last_wr_cyc, st_done_cyc, st_rdreq_cyc;
  int st_first, st_g1, st_d0cyc;
  bit st_p0_act;
  logic [AW-1:0] st_wraddr;
  logic [DW-1:0] st_rdata [$];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic any_out();
    return (p0_grant | p1_grant | p0_out_valid | p1_out_valid | p0_wr_next | p1_wr_next |
            p0_done | p1_done | mem_rdreq | mem_wrreq | (|mem_addr) | (|mem_in) |
            (|mem_burstlen) | (|p0_out) | (|p1_out));
  endfunction

  task automatic clear_stats();
    st_wr = 0; st_rdreq = 0; st_done[0] = 0; st_done[1] = 0; st_valid[0] = 0; st_valid[1] = 0;
    st_last_wr_cyc = -1; st_done_cyc = -1; st_rdreq_cyc = -1; st_first = -1; st_g1 = -1;
    st_d0cyc = -1; st_p0_act = 0; st_wraddr = '0; st_rdata.delete();
  endtask

  task automatic model_update();
    bit r0, r1;
    if (reset) begin
      md_busy = 0; md_fin = 0; md_ptr = 0;
    end else if (md_fin) begin
      md_busy = 0; md_fin = 0; md_ptr = 1 - md_owner;
    end else if (md_busy) begin
      md_age++;
      if (md_wr || mem_out_valid) begin
        md_beats++;
        if (md_beats == md_len) md_fin = 1;
      end
    end else begin
      r0 = m_rd[0] | m_wr[0];
      r1 = m_rd[1] | m_wr[1];
      if (r0 || r1) begin
        md_owner = (r0 && r1) ? md_ptr : (r1 ? 1 : 0);
        md_wr    = m_wr[md_owner];
        md_len   = (m_bl[md_owner] == '0) ? 1 : int'(m_bl[md_owner]);
        md_beats = 0; md_age = 0; md_busy = 1; md_fin = 0; just_acc = 1;
      end
    end
  endtask

  task automatic random_master(int i);
    int op;
    if (!m_act[i]) begin
      if ($urandom_range(3) == 0) begin
        op = $urandom_range(3);
        m_act[i] = 1; m_ab[i] = 0;
        m_rd[i] = (op != 2); m_wr[i] = (op >= 2);
        m_bl[i] = BW'($urandom_range(6));
        m_addr[i] = AW'($urandom_range(255)) << 2;
        m_in[i] = $urandom;
        zw_mode = bit'($urandom_range(1));
      end
    end else if (!m_ab[i] && md_busy && !md_fin && md_owner == i && md_age >= 1 &&
                 $urandom_range(31) == 0) begin
      m_ab[i] = 1; m_rd[i] = 0; m_wr[i] = 0;
    end
  endtask

  task automatic drive();
    if (reset) begin rd_left = 0; zw_started = 0; end
    for (int i = 0; i < 2; i++) begin
      if (ob_next[i]) begin m_addr[i] = m_addr[i] + 4; m_in[i] = m_in[i] + 1; end
      if (ob_done[i]) begin m_rd[i] = 0; m_wr[i] = 0; m_act[i] = 0; m_ab[i] = 0; end
      ob_next[i] = 0; ob_done[i] = 0;
      if (rnd_mode) random_master(i);
    end
    if (zw_mode && just_acc && !md_wr && !reset) begin
      rd_left = md_len; rd_ptr = int'(m_addr[md_owner][11:2]); zw_started = 1;
    end
    just_acc = 0;
    if (rd_left > 0 && $urandom_range(99) >= stall_pct) begin
      mem_out_valid = 1; mem_out = mem[rd_ptr & 1023]; rd_ptr++; rd_left--;
    end else if (rd_left == 0 && (force_stray || (stray_en && !m_rd[0] && !m_rd[1] &&
                 $urandom_range(7) == 0))) begin
      mem_out_valid = 1; mem_out = $urandom;
    end else begin
      mem_out_valid = 0; mem_out = $urandom;
    end
  endtask

  // single compare point against the model, once per cycle
  task automatic compare();
    logic [9:0] ec, ac;
    logic [AW-1:0] ea; logic [DW-1:0] ei, eo0, eo1; logic [BW-1:0] eb;
    ec = '0; ea = '0; ei = '0; eo0 = '0; eo1 = '0; eb = '0;
    if (md_busy && !md_fin) begin
      ec[9 - md_owner] = 1'b1;
      ea = m_addr[md_owner]; ei = m_in[md_owner]; eb = BW'(md_len);
      if (md_owner == 0) eo0 = mem_out; else eo1 = mem_out;
      if (md_wr) begin
        ec[5 - md_owner] = 1'b1; ec[0] = 1'b1;
      end else begin
        ec[1] = (md_age == 0);
        ec[7 - md_owner] = mem_out_valid;
      end
    end else if (md_busy) begin
      ec[3 - md_owner] = 1'b1;
    end
    ac = {p0_grant, p1_grant, p0_out_valid, p1_out_valid, p0_wr_next, p1_wr_next,
          p0_done, p1_done, mem_rdreq, mem_wrreq};
    chk("ctrl{g0,g1,ov0,ov1,wn0,wn1,d0,d1,rdreq,wrreq}", 64'(ac), 64'(ec));
    chk("mem_addr", 64'(mem_addr), 64'(ea));
    chk("mem_in", 64'(mem_in), 64'(ei));
    chk("mem_burstlen", 64'(mem_burstlen), 64'(eb));
    chk("p0_out", 64'(p0_out), 64'(eo0));
    chk("p1_out", 64'(p1_out), 64'(eo1));
  endtask

  task automatic observe();
    ob_next[0] = p0_wr_next; ob_next[1] = p1_wr_next;
    ob_done[0] = p0_done;    ob_done[1] = p1_done;
    if (mem_wrreq) begin
      mem[mem_addr[11:2]] = mem_in;
      st_wr++; if (st_wr == 1) st_wraddr = mem_addr; st_last_wr_cyc = cyc;
    end
    if (mem_rdreq) begin
      st_rdreq++; st_rdreq_cyc = cyc;
      if (zw_started) zw_started = 0;
      else begin rd_left = int'(mem_burstlen); rd_ptr = int'(mem_addr[11:2]); end
    end
    if (p0_done) begin st_done[0]++; st_done_cyc = cyc; st_d0cyc = cyc; end
    if (p1_done) begin st_done[1]++; st_done_cyc = cyc; end
    if (p0_out_valid) begin st_valid[0]++; st_rdata.push_back(p0_out); end
    if (p1_out_valid) begin st_valid[1]++; st_rdata.push_back(p1_out); end
    if (st_first < 0) begin
      if (p0_grant) st_first = 0; else if (p1_grant) st_first = 1;
    end
    if (p1_grant && st_g1 < 0) st_g1 = cyc;
    if (p0_grant || p0_out_valid || p0_done || p0_wr_next || p0_out != '0) st_p0_act = 1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    drive();
    @(negedge clk);
    cyc++;
    compare();
    observe();
  endtask

  task automatic wait_quiet(int lim);
    int n = 0;
    while (m_rd[0] | m_wr[0] | m_rd[1] | m_wr[1]) begin
      tick(); n++;
      if (n > lim) begin
        checks++;
        $display("FAIL timeout: requests still pending after %0d cycles, required done", n);
        m_rd[0] = 0; m_wr[0] = 0; m_rd[1] = 0; m_wr[1] = 0;
        break;
      end
    end
  endtask

  task automatic start(int p, bit wr, bit rd, logic [AW-1:0] a, int len, logic [DW-1:0] d);
    m_addr[p] = a; m_in[p] = d; m_bl[p] = BW'(len); m_wr[p] = wr; m_rd[p] = rd;
  endtask

  initial begin
    int n;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 2; i++) begin
      m_addr[i] = '0; m_in[i] = '0; m_rd[i] = 0; m_wr[i] = 0; m_bl[i] = '0;
      m_act[i] = 0; m_ab[i] = 0; ob_next[i] = 0; ob_done[i] = 0;
    end
    clear_stats();
    reset = 1; tick(); tick();
    chk("reset_outputs_zero", 64'(any_out()), 64'd0);
    reset = 0; tick();

    clear_stats(); start(1, 1, 0, 32'h80, 1, 32'h0fff0001); wait_quiet(100);
    chk("wr1_beats", 64'(st_wr), 64'd1);
    chk("wr1_addr", 64'(st_wraddr), 64'h80);
    chk("wr1_done_next_cycle", 64'(st_done_cyc - st_last_wr_cyc), 64'd1);

    clear_stats(); start(1, 0, 1, 32'h80, 1, 32'h0); wait_quiet(100);
    chk("rd1_rdreq_pulses", 64'(st_rdreq), 64'd1);
    chk("rd1_valid_beats", 64'(st_valid[1]), 64'd1);
    chk("rd1_data", 64'(st_rdata.size() > 0 ? st_rdata[0] : 32'hdeadbeef), 64'h0fff0001);
    chk("rd1_done", 64'(st_done[1]), 64'd1);
    chk("rd1_p0_quiet", 64'(st_p0_act), 64'd0);

    clear_stats(); start(0, 0, 1, 32'h80, 1, 0); start(1, 0, 1, 32'h80, 1, 0); wait_quiet(100);
    chk("contend1_first", 64'(st_first), 64'd0);
    chk("contend1_p1_after_done", 64'(st_g1 - st_d0cyc), 64'd2);
    clear_stats(); start(0, 0, 1, 32'h80, 1, 0); wait_quiet(100);
    clear_stats(); start(0, 0, 1, 32'h80, 1, 0); start(1, 0, 1, 32'h80, 1, 0); wait_quiet(100);
    chk("contend2_first", 64'(st_first), 64'd1);

    clear_stats(); start(1, 1, 0, 32'h180, 8, 32'h0fff1001); wait_quiet(100);
    chk("wr8_beats", 64'(st_wr), 64'd8);
    stall_pct = 25;
    clear_stats(); start(0, 0, 1, 32'h180, 8, 0); wait_quiet(200);
    chk("rd8_valid_beats", 64'(st_valid[0]), 64'd8);
    chk("rd8_done", 64'(st_done[0]), 64'd1);
    for (int k = 0; k < 8; k++)
      chk("rd8_data", 64'(k < st_rdata.size() ? st_rdata[k] : 32'hdeadbeef),
          64'(32'h0fff1001 + k));
    stall_pct = 0;

    zw_mode = 1;
    clear_stats(); start(0, 0, 1, 32'h80, 1, 0); wait_quiet(100);
    chk("zw_data", 64'(st_rdata.size() > 0 ? st_rdata[0] : 32'hdeadbeef), 64'h0fff0001);
    chk("zw_done_after_start", 64'(st_done_cyc - st_rdreq_cyc), 64'd1);
    zw_mode = 0;

    clear_stats(); start(0, 1, 0, 32'h200, 8, 32'h0aaa0000);
    n = 0;
    while (st_wr < 4 && n < 50) begin tick(); n++; end
    chk("rst_reached_beat4", 64'(st_wr), 64'd4);
    reset = 1; m_wr[0] = 0;
    tick();
    chk("rst_mid_outputs_zero", 64'(any_out()), 64'd0);
    reset = 0;
    clear_stats(); start(1, 0, 1, 32'h80, 1, 0); wait_quiet(100);
    chk("post_rst_data", 64'(st_rdata.size() > 0 ? st_rdata[0] : 32'hdeadbeef), 64'h0fff0001);
    chk("post_rst_done", 64'(st_done[1]), 64'd1);

    clear_stats(); start(0, 1, 1, 32'h300, 0, 32'h55); wait_quiet(100);
    chk("len0_single_beat", 64'(st_wr), 64'd1);
    chk("len0_rdwr_is_write_rdreqs", 64'(st_rdreq), 64'd0);

    clear_stats(); force_stray = 1; tick(); tick(); tick(); force_stray = 0; tick();
    chk("stray_no_out_valid", 64'(st_valid[0] + st_valid[1]), 64'd0);

    clear_stats(); rnd_mode = 1; stray_en = 1; stall_pct = 30;
    for (int k = 0; k < 3000; k++) tick();
    rnd_mode = 0;
    n = 0;
    while ((m_act[0] || m_act[1] || md_busy) && n < 500) begin tick(); n++; end
    if (n >= 500) begin
      checks++;
      $display("FAIL drain: traffic still active after %0d cycles, required idle", n);
    end
    chk("random_bursts_completed", 64'(st_done[0] + st_done[1] > 100), 64'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
